// File: rtl/shift_seq_ctrl.sv
// Shift-register sequencer: parallel load, then shift left or right a programmable
// number of times with a serial fill bit, followed by a one-cycle done pulse.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             leftOrRight,
    input  logic [WIDTH-1:0] d_in,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    input  logic             abort,
    output logic             ser_out,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] remaining;
    logic             dir_right;
    logic [CNT_W-1:0] eff_count;

    // Zero or out-of-range counts mean a full-width transfer.
    always_comb begin
        eff_count = count;
        if (count == '0 || 32'(count) > WIDTH) begin
            eff_count = CNT_W'(WIDTH);
        end
    end

    // Serial output follows the latched direction; forced low while idle.
    always_comb begin
        ser_out = 1'b0;
        if (state != StIdle) begin
            ser_out = dir_right ? out[0] : out[WIDTH-1];
        end
    end

    // Sequencer FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            out       <= '0;
            remaining <= '0;
            dir_right <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    // abort is ignored here, so start with abort still launches
                    if (start) begin
                        out       <= d_in;
                        dir_right <= leftOrRight;
                        remaining <= eff_count;
                        busy      <= 1'b1;
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (abort) begin
                        // Drop the transfer: no shift, contents held, no done pulse.
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        if (dir_right) begin
                            out <= {ser_in, out[WIDTH-1:1]};
                        end else begin
                            out <= {out[WIDTH-2:0], ser_in};
                        end
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: table of transfers checked cycle by cycle through an
// expectation queue, plus hand-written abort, start-while-busy and reset sequences.
module tb_shift_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             left_or_right;
    logic [WIDTH-1:0] d_in;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic             abort;
    logic             ser_out;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       right;
        logic [7:0] d;
        logic [3:0] cnt;
        logic       s;
        logic [7:0] exp_final;
        int         exp_n;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic       busy;
        logic       done;
        logic       ser;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    shift_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .leftOrRight(left_or_right),
        .d_in       (d_in),
        .count      (count),
        .ser_in     (ser_in),
        .abort      (abort),
        .ser_out    (ser_out),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] shift_ref(input logic [7:0] v, input logic right,
                                             input logic s);
        return right ? {s, v[7:1]} : {v[6:0], s};
    endfunction

    // Push the per-cycle expectations, launch the transfer, then pop and compare
    // while scrambling the load inputs to show they are ignored while busy.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t       e;
        exp_t       got;
        logic [7:0] m;
        m = v.d;
        @(negedge clk);
        start         = 1'b1;
        left_or_right = v.right;
        d_in          = v.d;
        count         = v.cnt;
        ser_in        = v.s;
        for (int i = 0; i < v.exp_n; i++) begin
            e = '{m, 1'b1, 1'b0, v.right ? m[0] : m[7]};
            exp_q.push_back(e);
            m = shift_ref(m, v.right, v.s);
        end
        e = '{m, 1'b1, 1'b1, v.right ? m[0] : m[7]};
        exp_q.push_back(e);
        e = '{m, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < v.exp_n + 2; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d c%0d queue", idx, i), 32'd0, 32'd1);
            end else begin
                got = exp_q.pop_front();
                check($sformatf("v%0d c%0d out", idx, i), 32'(out), 32'(got.out));
                check($sformatf("v%0d c%0d busy", idx, i), 32'(busy), 32'(got.busy));
                check($sformatf("v%0d c%0d done", idx, i), 32'(done), 32'(got.done));
                check($sformatf("v%0d c%0d ser_out", idx, i), 32'(ser_out), 32'(got.ser));
            end
            if (i < v.exp_n + 1) begin
                start         = 1'($urandom_range(0, 1));
                left_or_right = 1'($urandom_range(0, 1));
                d_in          = 8'($urandom);
                count         = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check($sformatf("v%0d final out", idx), 32'(out), 32'(v.exp_final));
    endtask

    initial begin
        // right, d_in, count, ser_in, expected final out, expected shifts
        vecs[0] = '{1'b1, 8'hA5, 4'd0,  1'b0, 8'h00, 8};
        vecs[1] = '{1'b0, 8'h81, 4'd1,  1'b1, 8'h03, 1};
        vecs[2] = '{1'b1, 8'hFF, 4'd12, 1'b0, 8'h00, 8};
        vecs[3] = '{1'b0, 8'h3C, 4'd2,  1'b0, 8'hF0, 2};
        vecs[4] = '{1'b1, 8'h0F, 4'd3,  1'b1, 8'hE1, 3};
        vecs[5] = '{1'b0, 8'h55, 4'd8,  1'b1, 8'hFF, 8};
        vecs[6] = '{1'b1, 8'h96, 4'd15, 1'b1, 8'hFF, 8};
        vecs[7] = '{1'b1, 8'hC3, 4'd1,  1'b0, 8'h61, 1};

        rst_n         = 1'b0;
        start         = 1'b0;
        left_or_right = 1'b0;
        d_in          = '0;
        count         = '0;
        ser_in        = 1'b0;
        abort         = 1'b0;
        #3;
        check("reset out", 32'(out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset ser_out", 32'(ser_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Abort after three left shifts of F0.
        @(negedge clk);
        start = 1'b1; left_or_right = 1'b0; d_in = 8'hF0; count = 4'd0; ser_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort pre out", 32'(out), 32'h80);
        check("abort pre busy", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort out", 32'(out), 32'h80);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort done c%0d", i), 32'(done), 32'h0);
            check($sformatf("abort out c%0d", i), 32'(out), 32'h80);
        end

        // Start together with abort in IDLE launches the transfer.
        start = 1'b1; abort = 1'b1; left_or_right = 1'b1; d_in = 8'h0F; count = 4'd2;
        ser_in = 1'b0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", 32'(busy), 32'h1);
        check("start+abort out", 32'(out), 32'h0F);
        repeat (2) @(negedge clk);
        check("start+abort done", 32'(done), 32'h1);
        check("start+abort final", 32'(out), 32'h03);
        @(negedge clk);
        check("start+abort idle", 32'(busy), 32'h0);

        // Restart with 00 during SHIFT of FF, then reset mid-transfer.
        start = 1'b1; left_or_right = 1'b1; d_in = 8'hFF; count = 4'd0; ser_in = 1'b1;
        @(negedge clk);
        d_in = 8'h00;
        check("restart pre out", 32'(out), 32'hFF);
        @(negedge clk);
        start = 1'b0;
        check("restart ignored out", 32'(out), 32'hFF);
        check("restart busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out", 32'(out), 32'h0);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst done", 32'(done), 32'h0);
        check("async rst ser_out", 32'(ser_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst done", 32'(done), 32'h0);
        start = 1'b1; left_or_right = 1'b0; d_in = 8'h81; count = 4'd1; ser_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post rst busy", 32'(busy), 32'h1);
        check("post rst ser_out", 32'(ser_out), 32'h1);
        @(negedge clk);
        check("post rst out", 32'(out), 32'h03);
        check("post rst done pulse", 32'(done), 32'h1);
        @(negedge clk);
        check("post rst done clear", 32'(done), 32'h0);
        check("post rst idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
